// File: rtl/alu_op_sequencer.sv
// Control sequencer for the 64-bit ALU: decodes opcodes into ALU control words,
// keeps the architectural Z/C/V/N flag register and runs shift-add multiplies.
module alu_op_sequencer #(
  parameter int DATA_W    = 64,
  parameter int MUL_ITERS = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  output logic [4:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_status
);

  // state | meaning
  // IDLE  | req_ready high, waiting for a request
  // EXEC  | single-cycle ALU op, result captured at cycle end
  // MUL   | MUL_ITERS shift-add iterations through the ALU adder
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_ITERS - 1);

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_ADC  = 4'h5;
  localparam logic [3:0] OP_SBC  = 4'h6;
  localparam logic [3:0] OP_CMP  = 4'h7;
  localparam logic [3:0] OP_LSL  = 4'h8;
  localparam logic [3:0] OP_LSR  = 4'h9;
  localparam logic [3:0] OP_NOR  = 4'hA;
  localparam logic [3:0] OP_NAND = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;

  localparam logic [4:0] SEL_ADD = 5'b10000;
  localparam logic [4:0] SEL_SUB = 5'b10010;

  state_t            state_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        flags_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_err_q;

  logic [4:0]        dec_sel;
  logic              dec_cin;
  logic              dec_arith;
  logic              dec_err;
  logic [3:0]        flags_d;
  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] acc_d;
  logic [3:0]        mul_flags_d;

  always_comb begin
    dec_sel   = 5'b00000;
    dec_cin   = 1'b0;
    dec_arith = 1'b0;
    dec_err   = 1'b0;
    case (op_q)
      OP_AND:  dec_sel = 5'b01000;
      OP_OR:   dec_sel = 5'b00100;
      OP_XOR:  dec_sel = 5'b01100;
      OP_ADD: begin
        dec_sel   = SEL_ADD;
        dec_arith = 1'b1;
      end
      OP_ADC: begin
        dec_sel   = SEL_ADD;
        dec_cin   = flags_q[1];
        dec_arith = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        dec_sel   = SEL_SUB;
        dec_cin   = 1'b1;
        dec_arith = 1'b1;
      end
      OP_SBC: begin
        dec_sel   = SEL_SUB;
        dec_cin   = flags_q[1];
        dec_arith = 1'b1;
      end
      OP_LSL:  dec_sel = 5'b11000;
      OP_LSR:  dec_sel = 5'b10100;
      OP_NOR:  dec_sel = 5'b01011;
      OP_NAND: dec_sel = 5'b00111;
      default: dec_err = 1'b1;
    endcase
  end

  // The ALU sees quiet zeros except while an op is actually using it.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_sel = 5'b00000;
    case (state_q)
      S_EXEC: begin
        if (!dec_err) begin
          alu_a   = a_q;
          alu_b   = b_q;
          alu_cin = dec_cin;
          alu_sel = dec_sel;
        end
      end
      S_MUL: begin
        alu_a   = acc_q;
        alu_b   = mcand_q;
        alu_sel = SEL_ADD;
      end
      default: ;
    endcase
  end

  always_comb begin
    flags_d  = flags_q;
    result_d = alu_out;
    if (dec_err) begin
      result_d = '0;
    end else begin
      flags_d[0] = alu_status[0];
      flags_d[3] = alu_status[3];
      if (dec_arith) begin
        flags_d[1] = alu_status[1];
        flags_d[2] = alu_status[2];
      end
      if (op_q == OP_CMP) result_d = '0;
    end
  end

  assign acc_d       = mplier_q[0] ? alu_out : acc_q;
  assign mul_flags_d = {acc_d[DATA_W-1], 1'b0, 1'b0, (acc_d == '0)};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= 4'h0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      flags_q      <= 4'h0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            a_q      <= req_a;
            b_q      <= req_b;
            acc_q    <= '0;
            mcand_q  <= req_a;
            mplier_q <= req_b;
            cnt_q    <= CNT_LOAD;
            state_q  <= (req_op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result_q <= result_d;
          rsp_err_q    <= dec_err;
          flags_q      <= flags_d;
          state_q      <= S_RESP;
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == '0) begin
            rsp_result_q <= acc_d;
            rsp_err_q    <= 1'b0;
            flags_q      <= mul_flags_d;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = rsp_err_q;

endmodule
